// File: rtl/vm_pkg.sv
// Vending-machine shared definitions.
// Amounts throughout the vending datapath are expressed in Rs.5 units, so a
// Rs.10 coin is worth 2 units and a Rs.5 coin is worth 1 unit.
// Contents: change dispenser state encoding, coin values, unit size.
package vm_pkg;

  // Rupees represented by one amount unit.
  localparam int unsigned UNIT_RUPEES = 5;

  // Coin values in amount units.
  localparam int unsigned COIN5  = 1;
  localparam int unsigned COIN10 = 2;

  typedef enum logic [2:0] {
    CD_IDLE,
    CD_SELECT,
    CD_PULSE,
    CD_WAIT_ACK,
    CD_DONE,
    CD_FAULT
  } cd_state_e;

endpackage

// File: rtl/change_dispenser_if.sv
// Bundle between the vending controller / hopper and the change dispenser.
// master: vending controller + hopper side (drives request and sensors).
// slave : change dispenser (drives solenoids and status).
// Signals:
//   req, amount        refund request and owed value (Rs.5 units)
//   empty10, empty5    hopper empty flags
//   coin_sensed        exit sensor pulse
//   fault_clr          clears a latched fault
//   eject10, eject5    solenoid drives
//   busy, done, fault  status; owed = remaining unpaid amount
interface change_dispenser_if #(
  parameter int unsigned AMT_W = 3
);

  logic             req;
  logic [AMT_W-1:0] amount;
  logic             empty10;
  logic             empty5;
  logic             coin_sensed;
  logic             fault_clr;
  logic             eject10;
  logic             eject5;
  logic             busy;
  logic             done;
  logic             fault;
  logic [AMT_W-1:0] owed;

  modport master (
    output req, amount, empty10, empty5, coin_sensed, fault_clr,
    input  eject10, eject5, busy, done, fault, owed
  );

  modport slave (
    input  req, amount, empty10, empty5, coin_sensed, fault_clr,
    output eject10, eject5, busy, done, fault, owed
  );

endinterface

// File: rtl/cd_timer.sv
// Loadable down-counter shared by the eject pulse length and the coin
// acknowledge timeout.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   load        load 'value' this cycle (wins over counting)
//   value       reload value
//   expired     count has reached zero
module cd_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: converts an owed amount (Rs.5 units) into a sequence of
// Rs.10 / Rs.5 eject pulses, confirms each coin on the exit sensor and
// reports done or a sticky fault.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    change_dispenser_if.slave (request, hopper sensors, solenoids,
//          busy/done/fault status and remaining owed amount)
//   cnt10, cnt5  confirmed coin counters (only when COIN_COUNT_EN is defined)
// Build option: define COIN_COUNT_EN to add the saturating coin counters.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int unsigned AMT_W     = 3,
  parameter int unsigned PULSE_LEN = 2,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  change_dispenser_if.slave       bus
`ifdef COIN_COUNT_EN
  ,
  output logic [7:0]              cnt10,
  output logic [7:0]              cnt5
`endif
);

  localparam int unsigned TMAX = (PULSE_LEN > TIMEOUT) ? PULSE_LEN : TIMEOUT;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  cd_state_e        state_q;
  logic [AMT_W-1:0] owed_q;
  logic             coin10_q;
  logic             eject10_q;
  logic             eject5_q;
  logic             busy_q;
  logic             done_q;
  logic             fault_q;

  logic             sel10;
  logic             sel5;
  logic             tmr_load;
  logic [TW-1:0]    tmr_value;
  logic             tmr_expired;

  // Coin choice; a Rs.10 coin needs at least 2 units owed so owed never
  // underflows.
  assign sel10 = (owed_q >= AMT_W'(COIN10)) && !bus.empty10;
  assign sel5  = (owed_q >= AMT_W'(COIN5))  && !bus.empty5;

  // The timer is reloaded on entry to PULSE (pulse length) and on entry to
  // WAIT_ACK (timeout); it holds N-1 so the state lasts exactly N cycles.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state_q)
      CD_SELECT: begin
        tmr_load  = 1'b1;
        tmr_value = TW'(PULSE_LEN - 1);
      end
      CD_PULSE: begin
        if (tmr_expired) begin
          tmr_load  = 1'b1;
          tmr_value = TW'(TIMEOUT - 1);
        end
      end
      default: ;
    endcase
  end

  cd_timer #(
    .W (TW)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  // Status and solenoid outputs are registered decodes of the current state,
  // so they trail the state register by one cycle (eject rises two edges
  // after the request is sampled). fault/busy are the exception on
  // fault_clr: they drop on the same edge that returns the FSM to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CD_IDLE;
      owed_q    <= '0;
      coin10_q  <= 1'b0;
      eject10_q <= 1'b0;
      eject5_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      eject10_q <= (state_q == CD_PULSE) && coin10_q;
      eject5_q  <= (state_q == CD_PULSE) && !coin10_q;
      done_q    <= (state_q == CD_DONE);
      busy_q    <= (state_q != CD_IDLE) && !((state_q == CD_FAULT) && bus.fault_clr);
      fault_q   <= (state_q == CD_FAULT) && !bus.fault_clr;

      case (state_q)
        CD_IDLE: begin
          if (bus.req) begin
            if (bus.amount != '0) begin
              owed_q  <= bus.amount;
              state_q <= CD_SELECT;
            end else begin
              state_q <= CD_DONE;
            end
          end
        end
        CD_SELECT: begin
          if (owed_q == '0) begin
            state_q <= CD_DONE;
          end else if (sel10) begin
            coin10_q <= 1'b1;
            state_q  <= CD_PULSE;
          end else if (sel5) begin
            coin10_q <= 1'b0;
            state_q  <= CD_PULSE;
          end else begin
            state_q <= CD_FAULT;
          end
        end
        CD_PULSE: begin
          if (tmr_expired) begin
            state_q <= CD_WAIT_ACK;
          end
        end
        CD_WAIT_ACK: begin
          if (bus.coin_sensed) begin
            owed_q  <= owed_q - (coin10_q ? AMT_W'(COIN10) : AMT_W'(COIN5));
            state_q <= CD_SELECT;
          end else if (tmr_expired) begin
            state_q <= CD_FAULT;
          end
        end
        CD_DONE: begin
          owed_q  <= '0;
          state_q <= CD_IDLE;
        end
        CD_FAULT: begin
          if (bus.fault_clr) begin
            owed_q  <= '0;
            state_q <= CD_IDLE;
          end
        end
        default: state_q <= CD_IDLE;
      endcase
    end
  end

  assign bus.eject10 = eject10_q;
  assign bus.eject5  = eject5_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.fault   = fault_q;
  assign bus.owed    = owed_q;

`ifdef COIN_COUNT_EN
  logic       accept;
  logic [7:0] cnt10_q;
  logic [7:0] cnt5_q;

  assign accept = (state_q == CD_WAIT_ACK) && bus.coin_sensed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt10_q <= '0;
      cnt5_q  <= '0;
    end else if (accept) begin
      if (coin10_q && (cnt10_q != '1)) begin
        cnt10_q <= cnt10_q + 8'd1;
      end
      if (!coin10_q && (cnt5_q != '1)) begin
        cnt5_q <= cnt5_q + 8'd1;
      end
    end
  end

  assign cnt10 = cnt10_q;
  assign cnt5  = cnt5_q;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser (AMT_W=3, PULSE_LEN=2,
// TIMEOUT=15). Inputs are driven and outputs sampled 1ns after each rising
// edge. Counter checks are included when COIN_COUNT_EN is defined.
module tb_change_dispenser;

  localparam int unsigned AMT_W     = 3;
  localparam int unsigned PULSE_LEN = 2;
  localparam int unsigned TIMEOUT   = 15;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   lat;

  change_dispenser_if #(.AMT_W(AMT_W)) bus ();

`ifdef COIN_COUNT_EN
  logic [7:0] cnt10;
  logic [7:0] cnt5;
`endif

  change_dispenser #(
    .AMT_W     (AMT_W),
    .PULSE_LEN (PULSE_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef COIN_COUNT_EN
    ,
    .cnt10 (cnt10),
    .cnt5  (cnt5)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle request; returns just after the edge that samples it.
  task automatic start_req(input logic [AMT_W-1:0] amt);
    bus.req    = 1'b1;
    bus.amount = amt;
    tick();
    bus.req    = 1'b0;
  endtask

  // Called just after the edge entering SELECT; returns just after the edge
  // that re-enters SELECT once the coin has been sensed.
  task automatic coin_cycle(input logic is10, input logic [AMT_W-1:0] owed_after);
    tick();
    check_eq("eject10_pre", bus.eject10, 0);
    check_eq("eject5_pre", bus.eject5, 0);
    for (int i = 0; i < PULSE_LEN; i++) begin
      tick();
      check_eq("eject10_on", bus.eject10, is10);
      check_eq("eject5_on", bus.eject5, !is10);
    end
    tick();
    check_eq("eject10_off", bus.eject10, 0);
    check_eq("eject5_off", bus.eject5, 0);
    bus.coin_sensed = 1'b1;
    tick();
    bus.coin_sensed = 1'b0;
    check_eq("owed_step", bus.owed, owed_after);
  endtask

  // From SELECT with owed already 0: DONE, done pulse, then idle.
  task automatic finish_done();
    tick();
    tick();
    check_eq("done_pulse", bus.done, 1);
    check_eq("done_owed", bus.owed, 0);
    tick();
    check_eq("done_low", bus.done, 0);
    check_eq("busy_after", bus.busy, 0);
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    reset           = 1'b1;
    bus.req         = 1'b0;
    bus.amount      = '0;
    bus.empty10     = 1'b0;
    bus.empty5      = 1'b0;
    bus.coin_sensed = 1'b0;
    bus.fault_clr   = 1'b0;
    tick();
    tick();
    check_eq("rst_eject10", bus.eject10, 0);
    check_eq("rst_eject5", bus.eject5, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_fault", bus.fault, 0);
    check_eq("rst_owed", bus.owed, 0);
    reset = 1'b0;
    tick();

    // amount 3: Rs.10 then Rs.5
    start_req(3'd3);
    check_eq("t1_owed_load", bus.owed, 3);
    coin_cycle(1'b1, 3'd1);
    coin_cycle(1'b0, 3'd0);
    finish_done();

    // amount 2 with Rs.10 hopper empty: two Rs.5
    bus.empty10 = 1'b1;
    start_req(3'd2);
    coin_cycle(1'b0, 3'd1);
    coin_cycle(1'b0, 3'd0);
    finish_done();
    bus.empty10 = 1'b0;
`ifdef COIN_COUNT_EN
    check_eq("cnt10_mid", cnt10, 1);
    check_eq("cnt5_mid", cnt5, 3);
`endif

    // amount 2, no coin ever sensed: timeout fault
    start_req(3'd2);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.fault) begin
        lat = i;
        break;
      end
    end
    check_eq("t3_fault_latency", lat, 19);
    check_eq("t3_owed", bus.owed, 2);
    check_eq("t3_busy", bus.busy, 1);
    tick();
    tick();
    check_eq("t3_fault_held", bus.fault, 1);
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    check_eq("t3_clr_fault", bus.fault, 0);
    check_eq("t3_clr_owed", bus.owed, 0);
    check_eq("t3_clr_busy", bus.busy, 0);
    tick();

    // amount 1 with Rs.5 hopper empty: immediate fault, no eject
    bus.empty5 = 1'b1;
    start_req(3'd1);
    tick();
    check_eq("t4_no_eject5", bus.eject5, 0);
    tick();
    check_eq("t4_fault", bus.fault, 1);
    check_eq("t4_owed", bus.owed, 1);
    check_eq("t4_no_eject10", bus.eject10, 0);
    start_req(3'd3);
    tick();
    check_eq("t4_req_ignored_owed", bus.owed, 1);
    check_eq("t4_req_ignored_fault", bus.fault, 1);
    bus.empty5    = 1'b0;
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    tick();

    // amount 0: done two cycles after req, busy exactly one cycle
    bus.req    = 1'b1;
    bus.amount = 3'd0;
    tick();
    check_eq("t5_busy_k", bus.busy, 0);
    check_eq("t5_done_k", bus.done, 0);
    bus.amount = 3'd4;
    tick();
    bus.req    = 1'b0;
    check_eq("t5_done", bus.done, 1);
    check_eq("t5_busy", bus.busy, 1);
    check_eq("t5_no_eject", bus.eject10 | bus.eject5, 0);
    tick();
    check_eq("t5_done_low", bus.done, 0);
    check_eq("t5_busy_low", bus.busy, 0);
    tick();
    check_eq("t5_ignored_busy", bus.busy, 0);
    check_eq("t5_ignored_owed", bus.owed, 0);

    // reset mid-pulse drops everything asynchronously
    start_req(3'd2);
    tick();
    tick();
    check_eq("t6_eject10_on", bus.eject10, 1);
    #1 reset = 1'b1;
    #1;
    check_eq("t6_rst_eject10", bus.eject10, 0);
    check_eq("t6_rst_busy", bus.busy, 0);
    check_eq("t6_rst_owed", bus.owed, 0);
    #1 reset = 1'b0;
    tick();
`ifdef COIN_COUNT_EN
    check_eq("cnt5_after_rst", cnt5, 0);
`endif
    start_req(3'd1);
    coin_cycle(1'b0, 3'd0);
    finish_done();

`ifdef COIN_COUNT_EN
    check_eq("cnt5_one", cnt5, 1);
    for (int n = 0; n < 254; n++) begin
      start_req(3'd1);
      coin_cycle(1'b0, 3'd0);
      finish_done();
    end
    check_eq("cnt5_255", cnt5, 255);
    start_req(3'd1);
    coin_cycle(1'b0, 3'd0);
    finish_done();
    check_eq("cnt5_sat", cnt5, 255);
    check_eq("cnt10_zero", cnt10, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Pays out refunds and change by driving the coin hopper.
- The vending FSM issues a request with an owed amount in Rs.5 units. This block converts it into a sequence of Rs.10 / Rs.5 eject pulses, confirms each coin via the hopper's coin sensor, and reports done or fault.
- Sits between the vending controller and the hopper solenoids and sensors.

Parameters:
- AMT_W, 3: width of the amount and owed value in Rs.5 units (max Rs.35).
- PULSE_LEN, 2: cycles an eject line is held high per coin; must be ≥1.
- TIMEOUT, 15: cycles to wait in WAIT_ACK for coin_sensed before fault; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  one-cycle refund request; sampled only in IDLE.
- amount  in  AMT_W  owed value in Rs.5 units; captured with req.
- empty10  in  1  Rs.10 hopper empty.
- empty5  in  1  Rs.5 hopper empty.
- coin_sensed  in  1  one-cycle pulse from the exit sensor when a coin drops.
- fault_clr  in  1  clears FAULT and returns to IDLE.
- eject10  out  1  Rs.10 solenoid drive.
- eject5  out  1  Rs.5 solenoid drive.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the full amount has been paid.
- fault  out  1  sticky fault flag.
- owed  out  AMT_W  remaining unpaid amount.

Behaviour:
- Reset values: all outputs 0, owed = 0, state IDLE, timers 0.
- All outputs are registered.
- States: IDLE, SELECT, PULSE, WAIT_ACK, DONE, FAULT.
- IDLE:
  - req with amount ≠ 0: owed ← amount, go to SELECT.
  - req with amount = 0: go to DONE.
  - req in any other state is ignored; no queuing.
- SELECT (one cycle): choose a coin, at most one coin type per cycle.
  - owed = 0 → DONE.
  - owed ≥ 2 and !empty10 → coin = 10.
  - otherwise owed ≥ 1 and !empty5 → coin = 5. This covers Rs.10 paid as two Rs.5 when empty10.
  - otherwise → FAULT.
- PULSE: the selected eject line is high for exactly PULSE_LEN consecutive cycles, then go to WAIT_ACK with the timer cleared.
  - eject10 and eject5 are never high together.
  - coin_sensed during PULSE is ignored.
- WAIT_ACK:
  - coin_sensed: owed ← owed − 2 (Rs.10) or owed − 1 (Rs.5), go to SELECT.
  - No coin_sensed within TIMEOUT cycles: go to FAULT; owed is unchanged.
- DONE: done = 1 for one cycle, owed = 0, go to IDLE.
- FAULT:
  - fault = 1 and busy = 1 are held; owed is held to show the unpaid amount.
  - fault_clr → IDLE next cycle, fault and owed cleared.
- Timing:
  - Request sampled at edge k: eject rises at edge k+2.
  - For a single coin with coin_sensed one cycle after the pulse ends, done pulses 3 cycles after the pulse ends.
- Arithmetic: owed never underflows. A Rs.10 coin is only selected when owed ≥ 2.
- Simultaneous events:
  - empty flags are sampled only in SELECT; changes during PULSE or WAIT_ACK do not abort the current coin.
  - fault_clr outside FAULT has no effect.
- Reset mid-operation: immediate return to IDLE; eject lines drop asynchronously; the partial payout is lost.

Optional Feature:
- Macro: COIN_COUNT_EN.
- Defined:
  - Adds outputs cnt10 [7:0] and cnt5 [7:0], counting confirmed coins per type.
  - Counters increment on each coin_sensed accepted in WAIT_ACK and saturate at 255.
  - Cleared only by reset.
- Undefined: the ports and counters do not exist.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package vm_pkg holds:
  - the state encoding;
  - coin value localparams COIN5 = 1 and COIN10 = 2 (Rs.5 units);
  - the amount-unit convention shared with the vending FSM.
- One sub-module, cd_timer: a loadable down-counter providing both the pulse-length and timeout counts. It has inputs load and value and output expired.

Test Plan:
- amount = 3, hoppers full, coin_sensed 1 cycle after each pulse → eject10 pulse (2 cycles), owed 3→1, then eject5 pulse, owed 1→0, done pulse, busy low after.
- amount = 2, empty10 = 1 → two eject5 pulses, never eject10; owed 2→1→0; done.
- amount = 2, coin_sensed never asserted → after PULSE_LEN + 15 cycles fault = 1, owed = 2, busy = 1; then fault_clr → IDLE, fault = 0, owed = 0.
- amount = 1, empty5 = 1 → SELECT goes to FAULT with no eject and owed = 1; a second req while faulted is ignored.
- amount = 0 → done 2 cycles after req, no eject, busy high for exactly 1 cycle. req during busy with amount = 4 is ignored.
- reset asserted mid-PULSE with eject10 high → eject10 and all outputs 0 immediately; a later req with amount = 1 completes normally. With COIN_COUNT_EN, 256 Rs.5 payouts leave cnt5 = 255.
